// File: rtl/stereo_pkg.sv
// Shared definitions for the stereo matching pipeline.
//  - Default pixel width, window length and sum width.
//  - Window sequencing state type (IDLE/ACCUM/DONE), shared with the
//    stage that walks windows across the image.
package stereo_pkg;

  localparam int DEF_PIX_W = 8;
  localparam int DEF_WIN_N = 256;
  localparam int DEF_SUM_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } win_state_e;

  // Counter width able to hold 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/window_sum_accum_if.sv
// Bus between the window accumulator and its neighbours.
//  Control : start (begin window, honoured in IDLE only), busy, state (debug).
//  Pixels  : pix_valid/pix_ready handshake carrying f_pix/g_pix.
//  Results : sums_valid/sums_ready handshake carrying the five sums.
// Handshake rule (both channels): a transfer happens on a rising clk edge
// where valid && ready. The producer holds valid and data stable until the
// transfer; ready never depends combinationally on valid.
// Modports: slave = accumulator side, master = upstream/downstream side.
interface window_sum_accum_if
  import stereo_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W,
  parameter int SUM_W = DEF_SUM_W
);
  logic             start;
  logic             pix_valid;
  logic             pix_ready;
  logic [PIX_W-1:0] f_pix;
  logic [PIX_W-1:0] g_pix;
  logic             sums_valid;
  logic             sums_ready;
  logic [SUM_W-1:0] fsum;
  logic [SUM_W-1:0] f2sum;
  logic [SUM_W-1:0] gsum;
  logic [SUM_W-1:0] g2sum;
  logic [SUM_W-1:0] fgsum;
  logic             busy;
  win_state_e       state;

  modport slave (
    input  start, pix_valid, f_pix, g_pix, sums_ready,
    output pix_ready, sums_valid, fsum, f2sum, gsum, g2sum, fgsum, busy, state
  );

  modport master (
    output start, pix_valid, f_pix, g_pix, sums_ready,
    input  pix_ready, sums_valid, fsum, f2sum, gsum, g2sum, fgsum, busy, state
  );

endinterface

// File: rtl/sum_lane.sv
// Registered accumulator lane.
//  clk, rst_n : clock, async active-low reset (sum cleared)
//  clear_i    : synchronous clear, wins over en_i
//  en_i       : add addend_i this cycle
//  addend_i   : SUM_W-bit addend, sum wraps modulo 2^SUM_W
//  sum_o      : current registered sum
module sum_lane #(
  parameter int SUM_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [SUM_W-1:0] addend_i,
  output logic [SUM_W-1:0] sum_o
);

  logic [SUM_W-1:0] sum_q;
  logic [SUM_W-1:0] sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clear_i) begin
      sum_d = '0;
    end else if (en_i) begin
      sum_d = sum_q + addend_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/window_sum_accum.sv
// Streaming window accumulator feeding the ZSSD formula stage.
// One window per start: accepts WIN_N f/g pixel pairs, then presents
// fsum, f2sum, gsum, g2sum, fgsum until downstream accepts them.
//  clk, rst_n : clock, async active-low reset
//  bus        : window_sum_accum_if.slave (start, pixel handshake,
//               sums handshake, busy, debug state)
// All bus outputs are registered, so pix_valid/sums_ready never reach an
// output combinationally.
module window_sum_accum
  import stereo_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W,
  parameter int WIN_N = DEF_WIN_N,
  parameter int SUM_W = DEF_SUM_W
) (
  input logic               clk,
  input logic               rst_n,
  window_sum_accum_if.slave bus
);

  localparam int CNT_W  = cnt_width(WIN_N);
  localparam int PROD_W = 2 * PIX_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIN_N - 1);
  localparam int N_LANES = 5;

  win_state_e       state_q;
  logic [CNT_W-1:0] count_q;
  logic             pix_ready_q;
  logic             sums_valid_q;
  logic             busy_q;

  logic accept;
  logic clear;

  // pix_ready_q is only ever high in ACCUM, so it alone qualifies acceptance.
  assign accept = bus.pix_valid && pix_ready_q;
  assign clear  = (state_q == ST_IDLE) && bus.start;

  // Window sequencer. Outputs are registered alongside the state so each
  // one switches on the same edge as the state that implies it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      pix_ready_q  <= 1'b0;
      sums_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q     <= ST_ACCUM;
            count_q     <= '0;
            pix_ready_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        ST_ACCUM: begin
          if (accept) begin
            count_q <= count_q + CNT_W'(1);
            if (count_q == LAST_CNT) begin
              state_q      <= ST_DONE;
              pix_ready_q  <= 1'b0;
              sums_valid_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          // start is deliberately ignored here, even alongside the handshake.
          if (bus.sums_ready) begin
            state_q      <= ST_IDLE;
            sums_valid_q <= 1'b0;
            busy_q       <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          pix_ready_q  <= 1'b0;
          sums_valid_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  // Zero-extended operands and unsigned full-width products.
  logic [PROD_W-1:0] f_ext;
  logic [PROD_W-1:0] g_ext;
  logic [PROD_W-1:0] ff_prod;
  logic [PROD_W-1:0] gg_prod;
  logic [PROD_W-1:0] fg_prod;

  assign f_ext   = PROD_W'(bus.f_pix);
  assign g_ext   = PROD_W'(bus.g_pix);
  assign ff_prod = f_ext * f_ext;
  assign gg_prod = g_ext * g_ext;
  assign fg_prod = f_ext * g_ext;

  // Lane order: fsum, f2sum, gsum, g2sum, fgsum.
  logic [SUM_W-1:0] addend [N_LANES];
  logic [SUM_W-1:0] sum    [N_LANES];

  assign addend[0] = SUM_W'(bus.f_pix);
  assign addend[1] = SUM_W'(ff_prod);
  assign addend[2] = SUM_W'(bus.g_pix);
  assign addend[3] = SUM_W'(gg_prod);
  assign addend[4] = SUM_W'(fg_prod);

  for (genvar l = 0; l < N_LANES; l++) begin : g_lane
    sum_lane #(
      .SUM_W (SUM_W)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear_i  (clear),
      .en_i     (accept),
      .addend_i (addend[l]),
      .sum_o    (sum[l])
    );
  end

  assign bus.fsum       = sum[0];
  assign bus.f2sum      = sum[1];
  assign bus.gsum       = sum[2];
  assign bus.g2sum      = sum[3];
  assign bus.fgsum      = sum[4];
  assign bus.pix_ready  = pix_ready_q;
  assign bus.sums_valid = sums_valid_q;
  assign bus.busy       = busy_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_window_sum_accum.sv
module tb_window_sum_accum;
  import stereo_pkg::*;

  localparam int WIN_N = 256;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  window_sum_accum_if bus ();

  window_sum_accum dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [159:0] exp_q[$];

  // Independent monitor of handshakes and ACCUM occupancy.
  int acc_cnt = 0;
  int accum_cyc = 0;
  always @(posedge clk) begin
    if (bus.pix_valid && bus.pix_ready) acc_cnt++;
    if (bus.state == ST_ACCUM) accum_cyc++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pix_f(input int mode, input int i);
    logic [31:0] v;
    v = i;
    case (mode)
      0: return 8'd255;
      1: return v[7:0];
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] pix_g(input int mode, input int i);
    logic [31:0] v;
    v = 255 - i;
    case (mode)
      0: return 8'd255;
      1: return v[7:0];
      default: return 8'd0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("start_state", 64'(bus.state), 64'(ST_ACCUM));
    check("start_pix_ready", 64'(bus.pix_ready), 64'd1);
    check("start_busy", 64'(bus.busy), 64'd1);
    check("start_cleared_fgsum", 64'(bus.fgsum), 64'd0);
  endtask

  // Sends n pairs of pattern mode; gap_pct percent of cycles idle.
  // start is pulsed while pair start_at is offered (ignored in ACCUM).
  task automatic send_window(input int mode, input int n, input int gap_pct, input int start_at);
    logic [31:0] mf, mf2, mg, mg2, mfg;
    logic [7:0] f, g;
    int waited;
    bit done;
    mf = 0; mf2 = 0; mg = 0; mg2 = 0; mfg = 0;
    for (int i = 0; i < n; i++) begin
      f = pix_f(mode, i);
      g = pix_g(mode, i);
      bus.f_pix = f;
      bus.g_pix = g;
      waited = 0;
      done = 1'b0;
      while (!done) begin
        bus.pix_valid = (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) ? 1'b0 : 1'b1;
        bus.start = (i == start_at);
        if (bus.pix_valid && bus.pix_ready) done = 1'b1;
        if (done && i == WIN_N - 1) check("sums_valid_early", 64'(bus.sums_valid), 64'd0);
        tick();
        waited++;
        if (!done && waited > 200) begin
          check("pix_accept_timeout", 64'(waited), 64'd0);
          bus.pix_valid = 1'b0;
          bus.start = 1'b0;
          return;
        end
      end
      mf  += 32'(f);
      mg  += 32'(g);
      mf2 += 32'(f) * 32'(f);
      mg2 += 32'(g) * 32'(g);
      mfg += 32'(f) * 32'(g);
    end
    bus.pix_valid = 1'b0;
    bus.start = 1'b0;
    if (n == WIN_N) begin
      exp_q.push_back({mf, mf2, mg, mg2, mfg});
      // One cycle after the final accept.
      check("sums_valid_latency", 64'(bus.sums_valid), 64'd1);
      check("pix_ready_drop", 64'(bus.pix_ready), 64'd0);
    end
  endtask

  task automatic check_sums(input string tag, input logic [159:0] e);
    check({tag, "_fsum"},  64'(bus.fsum),  64'(e[159:128]));
    check({tag, "_f2sum"}, 64'(bus.f2sum), 64'(e[127:96]));
    check({tag, "_gsum"},  64'(bus.gsum),  64'(e[95:64]));
    check({tag, "_g2sum"}, 64'(bus.g2sum), 64'(e[63:32]));
    check({tag, "_fgsum"}, 64'(bus.fgsum), 64'(e[31:0]));
  endtask

  // ---------------- scoreboard collect ----------------
  // Holds sums_ready low for hold cycles, then accepts. With hit_start,
  // start is driven during the hold and the handshake cycle.
  task automatic collect(input string tag, input int hold, input bit hit_start);
    logic [159:0] e;
    int waited;
    waited = 0;
    while (!bus.sums_valid && waited < 50) begin
      tick();
      waited++;
    end
    check({tag, "_sums_valid"}, 64'(bus.sums_valid), 64'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_exp_q_empty"}, 64'd0, 64'd1);
      return;
    end
    e = exp_q.pop_front();
    check_sums(tag, e);
    bus.start = hit_start;
    for (int c = 0; c < hold; c++) begin
      tick();
      check({tag, "_hold_valid"}, 64'(bus.sums_valid), 64'd1);
      check({tag, "_hold_pix_ready"}, 64'(bus.pix_ready), 64'd0);
      check({tag, "_hold_state"}, 64'(bus.state), 64'(ST_DONE));
      check_sums({tag, "_hold"}, e);
    end
    bus.sums_ready = 1'b1;
    tick();
    bus.sums_ready = 1'b0;
    bus.start = 1'b0;
    check({tag, "_idle_state"}, 64'(bus.state), 64'(ST_IDLE));
    check({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_idle_valid"}, 64'(bus.sums_valid), 64'd0);
    tick();
    check_sums({tag, "_idle"}, e);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base_acc, base_cyc;
    bus.start = 1'b0;
    bus.pix_valid = 1'b0;
    bus.f_pix = '0;
    bus.g_pix = '0;
    bus.sums_ready = 1'b0;

    #12;
    check("rst_state", 64'(bus.state), 64'(ST_IDLE));
    check("rst_pix_ready", 64'(bus.pix_ready), 64'd0);
    check("rst_sums_valid", 64'(bus.sums_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check_sums("rst", 160'd0);
    rst_n = 1'b1;
    tick();

    // 1: constant window, back-to-back
    do_start();
    base_acc = acc_cnt;
    base_cyc = accum_cyc;
    send_window(0, WIN_N, 0, -1);
    check("t1_accepts", 64'(acc_cnt - base_acc), 64'd256);
    check("t1_accum_cycles", 64'(accum_cyc - base_cyc), 64'd256);
    check("t1_const_fsum", 64'(bus.fsum), 64'd65280);
    check("t1_const_f2sum", 64'(bus.f2sum), 64'd16646400);
    collect("t1", 0, 1'b0);

    // 2: ramp
    do_start();
    send_window(1, WIN_N, 0, -1);
    check("t2_const_gsum", 64'(bus.gsum), 64'd32640);
    check("t2_const_g2sum", 64'(bus.g2sum), 64'd5559680);
    check("t2_const_fgsum", 64'(bus.fgsum), 64'd2763520);
    collect("t2", 0, 1'b0);

    // 3: throttled ramp
    do_start();
    base_acc = acc_cnt;
    send_window(1, WIN_N, 50, -1);
    check("t3_accepts", 64'(acc_cnt - base_acc), 64'd256);
    check("t3_const_fgsum", 64'(bus.fgsum), 64'd2763520);
    collect("t3", 0, 1'b0);

    // 4: backpressure in DONE
    do_start();
    send_window(1, WIN_N, 0, -1);
    collect("t4", 10, 1'b0);

    // 5: start in ACCUM and DONE ignored, then zero window
    do_start();
    send_window(1, WIN_N, 0, 50);
    collect("t5", 5, 1'b1);
    do_start();
    send_window(2, WIN_N, 20, -1);
    collect("t5_zero", 0, 1'b0);

    // 6: reset mid-window
    do_start();
    send_window(0, 100, 0, -1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_state", 64'(bus.state), 64'(ST_IDLE));
    check("t6_pix_ready", 64'(bus.pix_ready), 64'd0);
    check("t6_busy", 64'(bus.busy), 64'd0);
    check("t6_sums_valid", 64'(bus.sums_valid), 64'd0);
    check_sums("t6_rst", 160'd0);
    #3;
    rst_n = 1'b1;
    tick();
    do_start();
    send_window(1, WIN_N, 0, -1);
    collect("t6", 0, 1'b0);

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
